// File: rtl/col_page_read_scheduler.sv
// -----------------------------------------------------------------------------
// col_page_read_scheduler
//
// Issues memory read commands for column pages in the order the column-to-row
// assembler consumes them: page 0 of column 0, 1, ..., COL_COUNT-1, then page 1
// of every column, and so on. Every job starts at column 0 and issues
// page_count*COL_COUNT pages, so the assembler's round-robin buffer stays
// aligned from one job to the next. The assembler's page-completion pulse is
// used as credit return, which caps the number of pages in flight at
// MAX_OUTSTANDING.
//
// Ports:
//   clk             rising-edge clock for all logic
//   rst             synchronous, active-high reset; abandons any job at once
//   cfg_base        per-column base byte address, column i at
//                   [i*ADDR_WIDTH +: ADDR_WIDTH]
//   cfg_page_count  pages per column
//   cfg_page_words  memory words per page
//   cfg_valid       job request
//   cfg_ready       job accepted on cfg_valid & cfg_ready (IDLE and not in reset)
//   rd_cmd_addr     page byte address (registered)
//   rd_cmd_len      page length in memory words (registered)
//   rd_cmd_valid    command valid (registered)
//   rd_cmd_ready    command accepted on rd_cmd_valid & rd_cmd_ready
//   page_done       one pulse per page fully consumed by the assembler
//   busy            job in progress (ISSUE or DRAIN)
//   done            one-cycle pulse at job completion
//   err             sticky: page_done seen with nothing outstanding; cleared
//                   by the next job accept
// -----------------------------------------------------------------------------
module col_page_read_scheduler #(
    parameter int MEMORY_WIDTH    = 512,
    parameter int COL_COUNT       = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int PAGE_CNT_WIDTH  = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [COL_COUNT*ADDR_WIDTH-1:0] cfg_base,
    input  logic [PAGE_CNT_WIDTH-1:0]       cfg_page_count,
    input  logic [LEN_WIDTH-1:0]            cfg_page_words,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    output logic [ADDR_WIDTH-1:0]           rd_cmd_addr,
    output logic [LEN_WIDTH-1:0]            rd_cmd_len,
    output logic                            rd_cmd_valid,
    input  logic                            rd_cmd_ready,
    input  logic                            page_done,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    // Byte shift converting a word count into a byte count.
    localparam int BYTE_SHIFT = $clog2(MEMORY_WIDTH / 8);
    localparam int COL_IDX_W  = (COL_COUNT > 1) ? $clog2(COL_COUNT) : 1;
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [COL_IDX_W-1:0] COL_LAST  = COL_IDX_W'(COL_COUNT - 1);
    localparam logic [OUT_W-1:0]     OUT_LIMIT = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;

    // Per-column running page address.
    // NOTE: cur_addr is a storage array loaded on every job accept before it is
    // read, so it carries no reset; resetting it would only add reset fan-out.
    logic [ADDR_WIDTH-1:0]     cur_addr [COL_COUNT];

    logic [ADDR_WIDTH-1:0]     page_bytes;
    logic [LEN_WIDTH-1:0]      page_words;
    logic [PAGE_CNT_WIDTH-1:0] page_count;
    logic [PAGE_CNT_WIDTH-1:0] page_idx;
    logic [COL_IDX_W-1:0]      col_idx;
    logic [OUT_W-1:0]          outstanding;

    // Combinational helpers.
    logic                  cfg_accept;
    logic                  cmd_accept;
    logic [OUT_W-1:0]      outstanding_next;
    logic                  err_event;
    logic                  credit_ok;
    logic                  col_wrap;
    logic                  last_cmd;
    logic [COL_IDX_W-1:0]  col_idx_next;
    logic [ADDR_WIDTH-1:0] addr_upd;
    logic [ADDR_WIDTH-1:0] next_cmd_addr;

    assign cfg_ready  = (state == ST_IDLE) & ~rst;
    assign cfg_accept = cfg_valid & cfg_ready;
    assign cmd_accept = rd_cmd_valid & rd_cmd_ready;

    // Outstanding-page bookkeeping. An accept and a completion in the same
    // cycle cancel out; a completion with nothing in flight is flagged and
    // otherwise ignored so the count never underflows.
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        outstanding_next = outstanding;
        err_event        = 1'b0;
        if (page_done && (outstanding == '0) && !cmd_accept) begin
            err_event = 1'b1;
        end else if (cmd_accept && !page_done) begin
            outstanding_next = outstanding + OUT_W'(1);
        end else if (page_done && !cmd_accept) begin
            outstanding_next = outstanding - OUT_W'(1);
        end
    end

    // A new command may be presented next cycle only if the count, including
    // this cycle's accept and completion, leaves room for one more page.
    assign credit_ok = (outstanding_next < OUT_LIMIT);

    assign col_wrap     = (col_idx == COL_LAST);
    assign last_cmd     = col_wrap && (page_idx == page_count - PAGE_CNT_WIDTH'(1));
    assign col_idx_next = col_wrap ? '0 : col_idx + COL_IDX_W'(1);
    assign addr_upd     = cur_addr[col_idx] + page_bytes;

    // With a single column the next command hits the column just advanced,
    // whose register update is not visible until the next cycle.
    assign next_cmd_addr = (col_idx_next == col_idx) ? addr_upd : cur_addr[col_idx_next];

    // NOTE: all state below is sequential and uses non-blocking assignments so
    // every register samples the values that were current before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rd_cmd_valid <= 1'b0;
            rd_cmd_addr  <= '0;
            rd_cmd_len   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            outstanding  <= '0;
            col_idx      <= '0;
            page_idx     <= '0;
            page_count   <= '0;
            page_words   <= '0;
            page_bytes   <= '0;
        end else begin
            outstanding <= outstanding_next;
            done        <= 1'b0;
            if (err_event) begin
                err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_accept) begin
                        page_words <= cfg_page_words;
                        page_count <= cfg_page_count;
                        page_bytes <= ADDR_WIDTH'(cfg_page_words) << BYTE_SHIFT;
                        for (int i = 0; i < COL_COUNT; i++) begin
                            cur_addr[i] <= cfg_base[i*ADDR_WIDTH +: ADDR_WIDTH];
                        end
                        col_idx  <= '0;
                        page_idx <= '0;
                        // A completion racing the accept still gets recorded.
                        err      <= err_event;
                        if (cfg_page_count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= ST_ISSUE;
                            busy         <= 1'b1;
                            rd_cmd_valid <= credit_ok;
                            rd_cmd_addr  <= cfg_base[0 +: ADDR_WIDTH];
                            rd_cmd_len   <= cfg_page_words;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (cmd_accept) begin
                        cur_addr[col_idx] <= addr_upd;
                        col_idx           <= col_idx_next;
                        if (col_wrap) begin
                            page_idx <= page_idx + PAGE_CNT_WIDTH'(1);
                        end
                        if (last_cmd) begin
                            state        <= ST_DRAIN;
                            rd_cmd_valid <= 1'b0;
                        end else begin
                            rd_cmd_valid <= credit_ok;
                            rd_cmd_addr  <= next_cmd_addr;
                            rd_cmd_len   <= page_words;
                        end
                    end else if (!rd_cmd_valid) begin
                        // Waiting for credit; a presented command is held
                        // untouched until it is accepted.
                        rd_cmd_valid <= credit_ok;
                        rd_cmd_addr  <= cur_addr[col_idx];
                        rd_cmd_len   <= page_words;
                    end
                end

                ST_DRAIN: begin
                    if (outstanding_next == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_col_page_read_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for col_page_read_scheduler (default parameters: 3 columns,
// 512-bit words, 4 pages of credit). Directed scenarios, each in its own task,
// with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_col_page_read_scheduler;

    localparam int MEMORY_WIDTH    = 512;
    localparam int COL_COUNT       = 3;
    localparam int ADDR_WIDTH      = 32;
    localparam int LEN_WIDTH       = 16;
    localparam int PAGE_CNT_WIDTH  = 16;
    localparam int MAX_OUTSTANDING = 4;

    logic                            clk;
    logic                            rst;
    logic [COL_COUNT*ADDR_WIDTH-1:0] cfg_base;
    logic [PAGE_CNT_WIDTH-1:0]       cfg_page_count;
    logic [LEN_WIDTH-1:0]            cfg_page_words;
    logic                            cfg_valid;
    logic                            cfg_ready;
    logic [ADDR_WIDTH-1:0]           rd_cmd_addr;
    logic [LEN_WIDTH-1:0]            rd_cmd_len;
    logic                            rd_cmd_valid;
    logic                            rd_cmd_ready;
    logic                            page_done;
    logic                            busy;
    logic                            done;
    logic                            err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [ADDR_WIDTH-1:0] acc_log [32];
    int                    acc_n;

    col_page_read_scheduler #(
        .MEMORY_WIDTH    (MEMORY_WIDTH),
        .COL_COUNT       (COL_COUNT),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .LEN_WIDTH       (LEN_WIDTH),
        .PAGE_CNT_WIDTH  (PAGE_CNT_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_base       (cfg_base),
        .cfg_page_count (cfg_page_count),
        .cfg_page_words (cfg_page_words),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .rd_cmd_addr    (rd_cmd_addr),
        .rd_cmd_len     (rd_cmd_len),
        .rd_cmd_valid   (rd_cmd_valid),
        .rd_cmd_ready   (rd_cmd_ready),
        .page_done      (page_done),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; inputs driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a job for one accepted cycle; returns in the cycle after accept.
    task automatic start_job(input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [15:0] cnt,
                             input logic [15:0] words);
        int waited = 0;
        cfg_base       = {b2, b1, b0};
        cfg_page_count = cnt;
        cfg_page_words = words;
        while (cfg_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        tests_run++;
        if (cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_job_ready: cfg_ready got %b want 1", cfg_ready);
        end
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Accept every command and return a completion per page in flight until
    // done is seen; accepted addresses are appended to acc_log.
    task automatic drive_until_done(input int outs_in);
        int   outs = outs_in;
        logic acc;
        logic pd;
        bit   seen = 0;
        rd_cmd_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                pd        = (outs > 0);
                page_done = pd;
                acc       = (rd_cmd_valid === 1'b1);
                if (acc) begin
                    if (acc_n < 32) acc_log[acc_n] = rd_cmd_addr;
                    acc_n++;
                end
                tick();
                outs = outs + int'(acc) - int'(pd);
            end
        end
        page_done = 1'b0;
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL drive_until_done: done got 0 want 1 within 300 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (cfg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_cfg_ready_in_rst: got %b want 0", cfg_ready);
        end
        tests_run++;
        if ({rd_cmd_valid, busy, done, err} !== 4'b0000 || rd_cmd_addr !== 32'h0 || rd_cmd_len !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid/busy/done/err=%b addr=%h len=%h want all 0",
                     {rd_cmd_valid, busy, done, err}, rd_cmd_addr, rd_cmd_len);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_cfg_ready_after: got %b want 1", cfg_ready);
        end
    endtask

    task automatic test_basic_order();
        logic [31:0] exp_addr [6];
        logic [15:0] sched = '0;
        int n_acc = 0, n_pd = 0, last_pd_cyc = -1, done_cyc = -1;
        bit busy_bad = 0;
        exp_addr[0] = 32'h1000; exp_addr[1] = 32'h2000; exp_addr[2] = 32'h3000;
        exp_addr[3] = 32'h1100; exp_addr[4] = 32'h2100; exp_addr[5] = 32'h3100;
        rd_cmd_ready = 1'b1;
        start_job(32'h1000, 32'h2000, 32'h3000, 16'd2, 16'd4);
        for (int cyc = 0; cyc < 60 && done_cyc < 0; cyc++) begin
            page_done = sched[0];
            if (page_done) begin
                n_pd++;
                if (n_pd == 6) last_pd_cyc = cyc;
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                if (busy !== 1'b1) busy_bad = 1;
                if (rd_cmd_valid === 1'b1) begin
                    if (n_acc < 6) begin
                        tests_run++;
                        if (rd_cmd_addr !== exp_addr[n_acc] || rd_cmd_len !== 16'd4) begin
                            tests_failed++;
                            $display("FAIL basic_cmd[%0d]: addr=%h len=%0d want addr=%h len=4",
                                     n_acc, rd_cmd_addr, rd_cmd_len, exp_addr[n_acc]);
                        end
                    end
                    n_acc++;
                    sched[5] = 1'b1;
                end
            end
            tick();
            sched = sched >> 1;
        end
        page_done = 1'b0;
        tests_run++;
        if (n_acc != 6) begin
            tests_failed++;
            $display("FAIL basic_count: accepted %0d want 6", n_acc);
        end
        tests_run++;
        if (busy_bad) begin
            tests_failed++;
            $display("FAIL basic_busy: busy dropped before done, want 1 throughout");
        end
        tests_run++;
        if (done_cyc < 0 || done_cyc != last_pd_cyc + 1) begin
            tests_failed++;
            $display("FAIL basic_done_timing: done at cycle %0d want %0d", done_cyc, last_pd_cyc + 1);
        end
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_err: got %b want 0", err);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_after_done: done=%b cfg_ready=%b want done=0 cfg_ready=1", done, cfg_ready);
        end
    endtask

    task automatic test_credit_limit();
        int n_acc = 0;
        rd_cmd_ready = 1'b1;
        page_done    = 1'b0;
        start_job(32'h1000, 32'h2000, 32'h3000, 16'd2, 16'd4);
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (rd_cmd_valid === 1'b1) n_acc++;
            tick();
        end
        tests_run++;
        if (n_acc != 4 || rd_cmd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL credit_stall: accepted %0d valid=%b want 4 and valid=0", n_acc, rd_cmd_valid);
        end
        page_done = 1'b1;
        tick();
        page_done = 1'b0;
        tests_run++;
        if (rd_cmd_valid !== 1'b1 || rd_cmd_addr !== 32'h2100) begin
            tests_failed++;
            $display("FAIL credit_release: valid=%b addr=%h want valid=1 addr=00002100", rd_cmd_valid, rd_cmd_addr);
        end
        n_acc = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (rd_cmd_valid === 1'b1) n_acc++;
            tick();
        end
        tests_run++;
        if (n_acc != 1) begin
            tests_failed++;
            $display("FAIL credit_one_more: accepted %0d want 1", n_acc);
        end
        acc_n = 0;
        drive_until_done(4);
        tests_run++;
        if (acc_n != 1 || acc_log[0] !== 32'h3100) begin
            tests_failed++;
            $display("FAIL credit_tail: accepted %0d first=%h want 1 at 00003100", acc_n, acc_log[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr [6];
        logic [31:0] held;
        bit stable_bad = 0;
        exp_addr[0] = 32'h1000; exp_addr[1] = 32'h2000; exp_addr[2] = 32'h3000;
        exp_addr[3] = 32'h1100; exp_addr[4] = 32'h2100; exp_addr[5] = 32'h3100;
        acc_n        = 0;
        rd_cmd_ready = 1'b1;
        page_done    = 1'b0;
        start_job(32'h1000, 32'h2000, 32'h3000, 16'd2, 16'd4);
        if (rd_cmd_valid === 1'b1) begin
            acc_log[acc_n] = rd_cmd_addr;
            acc_n++;
        end
        tick();
        rd_cmd_ready = 1'b0;
        held = rd_cmd_addr;
        tests_run++;
        if (rd_cmd_valid !== 1'b1 || held !== 32'h2000) begin
            tests_failed++;
            $display("FAIL bp_second_cmd: valid=%b addr=%h want valid=1 addr=00002000", rd_cmd_valid, held);
        end
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            if (cyc < 2 && (rd_cmd_valid !== 1'b1 || rd_cmd_addr !== held || rd_cmd_len !== 16'd4))
                stable_bad = 1;
        end
        tests_run++;
        if (stable_bad || rd_cmd_valid !== 1'b1 || rd_cmd_addr !== held) begin
            tests_failed++;
            $display("FAIL bp_stable: valid=%b addr=%h len=%0d want valid=1 addr=%h len=4 held",
                     rd_cmd_valid, rd_cmd_addr, rd_cmd_len, held);
        end
        drive_until_done(1);
        tests_run++;
        if (acc_n != 6) begin
            tests_failed++;
            $display("FAIL bp_count: accepted %0d want 6", acc_n);
        end
        for (int i = 0; i < 6 && i < acc_n; i++) begin
            tests_run++;
            if (acc_log[i] !== exp_addr[i]) begin
                tests_failed++;
                $display("FAIL bp_seq[%0d]: got %h want %h", i, acc_log[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_zero_pages();
        bit cmd_seen = 0;
        rd_cmd_ready = 1'b1;
        page_done    = 1'b0;
        start_job(32'h4000, 32'h5000, 32'h6000, 16'd0, 16'd4);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0 || rd_cmd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done_cycle: done=%b busy=%b cfg_ready=%b valid=%b want 1 0 0 0",
                     done, busy, cfg_ready, rd_cmd_valid);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_after: done=%b busy=%b cfg_ready=%b want 0 0 1", done, busy, cfg_ready);
        end
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (rd_cmd_valid !== 1'b0 || busy !== 1'b0) cmd_seen = 1;
            tick();
        end
        tests_run++;
        if (cmd_seen) begin
            tests_failed++;
            $display("FAIL zero_no_cmd: command or busy seen, want none");
        end
    endtask

    task automatic test_counter_edges();
        int n_acc = 0;
        // Same-cycle accept and completion at a count of 2.
        rd_cmd_ready = 1'b1;
        page_done    = 1'b0;
        start_job(32'h1000, 32'h2000, 32'h3000, 16'd2, 16'd4);
        tick();
        tick();
        tests_run++;
        if (rd_cmd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL edge_third_valid: got %b want 1", rd_cmd_valid);
        end
        page_done = 1'b1;
        tick();
        page_done = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (rd_cmd_valid === 1'b1) n_acc++;
            tick();
        end
        tests_run++;
        if (n_acc != 2) begin
            tests_failed++;
            $display("FAIL edge_same_cycle: further accepts %0d want 2 (count held at 2)", n_acc);
        end
        acc_n = 0;
        drive_until_done(4);
        tick();

        // Completion with nothing outstanding, while idle.
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge_err_before: got %b want 0", err);
        end
        page_done = 1'b1;
        tick();
        page_done = 1'b0;
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL edge_err_set: got %b want 1", err);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL edge_err_sticky: got %b want 1", err);
        end
        start_job(32'h1000, 32'h2000, 32'h3000, 16'd2, 16'd4);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge_err_clear: got %b want 0", err);
        end
        n_acc = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (rd_cmd_valid === 1'b1) n_acc++;
            tick();
        end
        tests_run++;
        if (n_acc != 4) begin
            tests_failed++;
            $display("FAIL edge_idle_count: accepts %0d want 4 (count stayed 0)", n_acc);
        end
        drive_until_done(4);
    endtask

    task automatic test_reset_mid_job();
        logic [31:0] exp_addr [6];
        exp_addr[0] = 32'h5000; exp_addr[1] = 32'h6000; exp_addr[2] = 32'h7000;
        exp_addr[3] = 32'h5080; exp_addr[4] = 32'h6080; exp_addr[5] = 32'h7080;
        rd_cmd_ready = 1'b1;
        page_done    = 1'b0;
        start_job(32'h1000, 32'h2000, 32'h3000, 16'd2, 16'd4);
        tick();
        tick();
        rd_cmd_ready = 1'b0;
        rst          = 1'b1;
        #1;
        tests_run++;
        if (cfg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_cfg_ready_in_rst: got %b want 0", cfg_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (rd_cmd_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: valid=%b busy=%b err=%b done=%b cfg_ready=%b want 0 0 0 0 1",
                     rd_cmd_valid, busy, err, done, cfg_ready);
        end
        acc_n = 0;
        start_job(32'h5000, 32'h6000, 32'h7000, 16'd2, 16'd2);
        tests_run++;
        if (rd_cmd_valid !== 1'b1 || rd_cmd_addr !== 32'h5000 || rd_cmd_len !== 16'd2) begin
            tests_failed++;
            $display("FAIL rst_mid_first_cmd: valid=%b addr=%h len=%0d want 1 00005000 2",
                     rd_cmd_valid, rd_cmd_addr, rd_cmd_len);
        end
        drive_until_done(0);
        tests_run++;
        if (acc_n != 6) begin
            tests_failed++;
            $display("FAIL rst_mid_count: accepted %0d want 6", acc_n);
        end
        for (int i = 0; i < 6 && i < acc_n; i++) begin
            tests_run++;
            if (acc_log[i] !== exp_addr[i]) begin
                tests_failed++;
                $display("FAIL rst_mid_seq[%0d]: got %h want %h", i, acc_log[i], exp_addr[i]);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        cfg_base       = '0;
        cfg_page_count = '0;
        cfg_page_words = '0;
        cfg_valid      = 1'b0;
        rd_cmd_ready   = 1'b0;
        page_done      = 1'b0;
        acc_n          = 0;

        test_reset();
        test_basic_order();
        test_credit_limit();
        test_backpressure();
        test_zero_pages();
        test_counter_edges();
        test_reset_mid_job();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/col_page_read_scheduler.md
# col_page_read_scheduler

Issues memory read commands that fetch column pages for the column-to-row assembler in the order it consumes them. Each page goes to column 0, then 1, …, then COL_COUNT-1, then page 1 of every column, and so on. Sits between the job configuration port and the memory read-command channel. Uses the assembler's page-completion pulse (`input_valid & input_ready & input_last`) as credit return, so no more than MAX_OUTSTANDING pages are ever in flight.

## Interface
Parameters:
- MEMORY_WIDTH, 512, memory word width in bits; one page word = MEMORY_WIDTH/8 bytes (power of two).
- COL_COUNT, 3, number of columns per job.
- ADDR_WIDTH, 32, byte-address width.
- LEN_WIDTH, 16, page length field width, in memory words.
- PAGE_CNT_WIDTH, 16, pages-per-column counter width.
- MAX_OUTSTANDING, 4, maximum pages issued but not yet completed (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_base  in  COL_COUNT*ADDR_WIDTH  per-column base byte address; column i is at [i*ADDR_WIDTH +: ADDR_WIDTH].
- cfg_page_count  in  PAGE_CNT_WIDTH  pages per column.
- cfg_page_words  in  LEN_WIDTH  memory words per page.
- cfg_valid  in  1  job request.
- cfg_ready  out  1  job accepted when cfg_valid & cfg_ready.
- rd_cmd_addr  out  ADDR_WIDTH  page byte address.
- rd_cmd_len  out  LEN_WIDTH  page length in words.
- rd_cmd_valid  out  1  command valid.
- rd_cmd_ready  in  1  command accepted when rd_cmd_valid & rd_cmd_ready.
- page_done  in  1  one pulse per page fully consumed by the assembler.
- busy  out  1  job in progress (ISSUE or DRAIN).
- done  out  1  one-cycle pulse at job completion.
- err  out  1  sticky: page_done arrived with zero outstanding.

## Operation
- States are IDLE, ISSUE, DRAIN and DONE.
- **IDLE:**
  - cfg_ready = (state==IDLE) & !rst, combinational.
  - On cfg_valid & cfg_ready: latch cfg_page_words and cfg_page_count, and load cur_addr[i] = base[i] for every column.
  - page_bytes = cfg_page_words << log2(MEMORY_WIDTH/8), truncated to ADDR_WIDTH.
  - Clear col_idx and page_idx. Clear err.
  - If cfg_page_count == 0, go to DONE; otherwise go to ISSUE.
- **ISSUE:**
  - The command carries addr = cur_addr[col_idx] and len = page_words.
  - On accept: cur_addr[col_idx] += page_bytes, modulo 2^ADDR_WIDTH with no wrap detection.
  - Also on accept: col_idx increments; at COL_COUNT-1 it wraps to 0 and page_idx increments.
  - Accepting the command where col_idx == COL_COUNT-1 and page_idx == page_count-1 moves the FSM to DRAIN.
- **DRAIN:** wait until outstanding == 0, then go to DONE.
- **DONE:** assert done for exactly one cycle, then go to IDLE.
- **Outstanding counter**, width clog2(MAX_OUTSTANDING+1), reset 0:
  - Command accept alone: +1.
  - page_done alone: -1.
  - Both in the same cycle: unchanged.
  - page_done while outstanding == 0: no change; set err. This applies in any state, including IDLE.
- **Alignment:** every job starts at column 0 and issues page_count*COL_COUNT pages. This keeps the assembler's buffer round-robin aligned across jobs.

## Timing
- **Reset values:** the cycle after rst is sampled high, all outputs are 0: rd_cmd_valid, rd_cmd_addr, rd_cmd_len, busy, done, err. cfg_ready is 0 while rst is high and 1 afterwards. rst mid-job abandons the job immediately, with no drain.
- **Command issue:**
  - rd_cmd_valid, rd_cmd_addr and rd_cmd_len are registered outputs.
  - The first command is valid 1 cycle after cfg accept, provided credit is available.
  - Credit decision: rd_cmd_valid rises in cycle N+1 iff, in cycle N, state is ISSUE, commands remain, and outstanding_next < MAX_OUTSTANDING. outstanding_next includes cycle N's accept and page_done.
- **Handshake rules:**
  - Once rd_cmd_valid is high, valid, addr and len hold stable until accepted.
  - Throughput is one command per cycle while rd_cmd_ready = 1 and credit is available.
- **Status outputs:**
  - busy is 1 from the cycle after cfg accept through the cycle before done.
  - For page_count == 0: done is high exactly 1 cycle after cfg accept, busy stays 0, and cfg_ready is low during the done cycle.
  - Normal job: done is high 1 cycle after the page_done that drives outstanding to 0 in DRAIN.
  - cfg_ready returns to 1 the cycle after done.

## Test plan
1. **Basic ordering.**
   - Stimulus: bases 0x1000/0x2000/0x3000, page_count = 2, page_words = 4, MEMORY_WIDTH = 512, rd_cmd_ready = 1, page_done 5 cycles after each accept.
   - Response: addresses 0x1000, 0x2000, 0x3000, 0x1100, 0x2100, 0x3100, all with len 4; busy high throughout; one done pulse 1 cycle after the 6th page_done.
2. **Credit limit.**
   - Stimulus: MAX_OUTSTANDING = 4, page_done held low.
   - Response: exactly 4 commands accepted, then rd_cmd_valid = 0. A single page_done pulse releases exactly one further command, valid the next cycle.
3. **Backpressure.**
   - Stimulus: rd_cmd_ready low for 3 cycles while the 2nd command is valid.
   - Response: addr and len stay stable during the stall; the accepted sequence has no skipped or duplicated address.
4. **Zero pages.**
   - Stimulus: page_count = 0.
   - Response: no commands issued; done high 1 cycle after cfg accept; busy stays 0.
5. **Counter edge cases.**
   - Stimulus: accept and page_done in the same cycle at outstanding = 2.
   - Response: the count stays 2.
   - Stimulus: page_done in IDLE.
   - Response: err = 1 and stays 1 until the next cfg accept; the count stays 0.
6. **Reset mid-job.**
   - Stimulus: rst pulsed for 1 cycle in ISSUE with 2 pages outstanding.
   - Response: next cycle rd_cmd_valid, busy and err are 0 and cfg_ready is 1. The following job's first command addresses the column-0 base.
